seven_seg_scan_mux: RTL and testbench

Upstream time-multiplex scanner for the 4-digit common-anode 7-segment display.
- Holds a 16-bit value as four hex nibbles and cycles through the digits at a fixed refresh rate.
- Presents one nibble per slot on x, which feeds hex_to_7_seg_2 directly.
- Drives the active-low digit anodes.
- Double-buffers the value so a digit update never tears mid-frame.

---
 rtl/seg_disp_pkg.sv | 12 +
 rtl/refresh_tick_gen.sv | 23 ++
 rtl/seven_seg_scan_mux.sv | 77 +++++++
 tb/tb_seven_seg_scan_mux.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the 7-segment display path.
package seg_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

    // Nibble k of value sits at bits [4k+3:4k].
    function automatic logic [3:0] nibble_sel(input logic [15:0] value, input logic [1:0] idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1, tick marks the last cycle of each slot.
module refresh_tick_gen #(
    parameter int DIV = 50000,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] count,
    output logic          tick
);

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// 4-digit common-anode scan multiplexer with frame-aligned double buffering
// and a per-slot blanking window ahead of each lit digit.
module seven_seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [3:0]            x,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0]           count;
    logic [CW-1:0]           count_nxt;
    logic                    tick;
    logic [1:0]              idx;
    logic [1:0]              idx_nxt;
    logic                    wrap;
    logic [15:0]             pending;
    logic                    pending_valid;
    logic [15:0]             active;
    logic [15:0]             active_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    refresh_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .tick  (tick)
    );

    // Outputs are decoded from next-state so an/x move on the same edge as idx.
    always_comb begin
        count_nxt  = tick ? '0 : count + 1'b1;
        idx_nxt    = tick ? idx + 2'd1 : idx;
        wrap       = tick && (idx == 2'd3);
        active_nxt = (wrap && pending_valid) ? pending : active;
        an_nxt     = AN_ALL_OFF;
        if ((count_nxt >= CW'(BLANK_CYCLES)) && digit_en[idx_nxt])
            an_nxt[idx_nxt] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= 2'd0;
            pending       <= 16'h0000;
            pending_valid <= 1'b0;
            active        <= 16'h0000;
            x             <= 4'h0;
            an            <= AN_ALL_OFF;
            frame_start   <= 1'b0;
        end else begin
            idx <= idx_nxt;
            // A load landing on the wrap cycle is kept for the next frame;
            // the wrap itself consumes the previous pending value.
            if (load) begin
                pending       <= value;
                pending_valid <= 1'b1;
            end else if (wrap) begin
                pending_valid <= 1'b0;
            end
            active      <= active_nxt;
            x           <= nibble_sel(active_nxt, idx_nxt);
            an          <= an_nxt;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_seven_seg_scan_mux;

    localparam int DIV   = 4;
    localparam int BLK   = 1;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        frame_start;

    seven_seg_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .load        (load),
        .digit_en    (digit_en),
        .x           (x),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    typedef struct {
        int unsigned at;
        logic [15:0] val;
    } load_t;

    exp_t        expq[$];
    load_t       loads[$];
    int unsigned n = 0;
    int          total = 0;
    int          bad = 0;

    // Reference: n edges after reset, the slot is n/DIV, the phase n%DIV, and
    // the shown value is the latest load accepted strictly before the most
    // recent frame boundary.
    always @(posedge clk) begin
        exp_t        e;
        load_t       l;
        int unsigned f;
        int unsigned p;
        int unsigned d;
        logic [15:0] act;
        if (!rst_n) begin
            n = 0;
            loads.delete();
            e.x  = 4'h0;
            e.an = 4'hF;
            e.fs = 1'b0;
        end else begin
            n++;
            f   = (n / FRAME) * FRAME;
            act = 16'h0000;
            foreach (loads[i])
                if (loads[i].at < f) act = loads[i].val;
            if (load) begin
                l.at  = n;
                l.val = value;
                loads.push_back(l);
            end
            p    = n % DIV;
            d    = (n / DIV) % 4;
            e.x  = act[d*4 +: 4];
            e.an = (p < BLK || !digit_en[d]) ? 4'hF : ~(4'b0001 << d);
            e.fs = (n % FRAME == 0);
        end
        expq.push_back(e);
    end

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t n=%0d got=%h want=%h", nm, $time, n, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("x", x, e.x);
            check("an", an, e.an);
            check("frame_start", {3'b000, frame_start}, {3'b000, e.fs});
        end
    end

    // Wait (at negedges) until the coming edge lands on frame phase ph.
    task automatic wait_phase(input int unsigned ph);
        int k;
        k = 0;
        while (((n + 1) % FRAME) != ph && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= 4 * FRAME) begin
            bad++;
            $display("FAIL wait_phase timeout ph=%0d", ph);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = 16'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // steady scan
        pulse_load(16'hA3F7);
        repeat (2 * FRAME + 2) @(negedge clk);

        // tear-free update in slot 1
        pulse_load(16'h5678);
        repeat (2 * FRAME) @(negedge clk);
        wait_phase(DIV + 1);
        pulse_load(16'h1234);
        repeat (2 * FRAME) @(negedge clk);

        // load coincident with frame wrap
        wait_phase(10);
        pulse_load(16'h1111);
        wait_phase(0);
        pulse_load(16'h2222);
        repeat (3 * FRAME) @(negedge clk);

        // digit enable mask
        digit_en = 4'b0101;
        repeat (2 * FRAME) @(negedge clk);
        digit_en = 4'hF;

        // mid-slot reset with a pending load outstanding
        wait_phase(9);
        pulse_load(16'hBEEF);
        wait_phase(11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        // randomized traffic
        repeat (800) begin
            @(negedge clk);
            load  = ($urandom % 6 == 0);
            value = 16'($urandom);
            if ($urandom % 40 == 0) digit_en = 4'($urandom);
            rst_n = ($urandom % 300 != 0);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
